mouse_cursor_tracker: RTL and testbench

MOUSE_CURSOR_TRACKER -- requirements
Module: mouse_cursor_tracker

---
 rtl/mouse_cursor_tracker.sv | 151 +++++++++++++++
 tb/tb_mouse_cursor_tracker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cursor_tracker.sv
// Mouse cursor tracker.
// Once per video frame: captures the mouse target, clamps it to the
// visible area, then moves the cursor toward it by at most MAX_STEP
// pixels per axis. A frame_start that arrives during a pass is remembered
// (pending) so that it triggers one follow-up pass.
module mouse_cursor_tracker #(
    parameter int H_MAX    = 639,
    parameter int V_MAX    = 479,
    parameter int MAX_STEP = 8,
    parameter int RESET_X  = 320,
    parameter int RESET_Y  = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        frame_start,
    input  logic [11:0] mouse_x_in,
    input  logic [11:0] mouse_y_in,
    output logic [9:0]  cursor_x,
    output logic [9:0]  cursor_y,
    output logic        pos_valid,
    output logic        moving,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CLAMP   = 2'd2,
        MOVE    = 2'd3
    } state_t;

    localparam logic [9:0]         H_LIM    = 10'(H_MAX);
    localparam logic [9:0]         V_LIM    = 10'(V_MAX);
    localparam logic [9:0]         STEP_U   = 10'(MAX_STEP);
    localparam logic signed [11:0] STEP_POS = 12'(MAX_STEP);
    localparam logic signed [11:0] STEP_NEG = 12'(-MAX_STEP);
    localparam logic [9:0]         RST_X    = 10'(RESET_X);
    localparam logic [9:0]         RST_Y    = 10'(RESET_Y);

    state_t             state;
    state_t             state_next;
    logic               pending;
    logic signed [11:0] cap_x;
    logic signed [11:0] cap_y;
    logic [9:0]         target_x;
    logic [9:0]         target_y;
    logic [9:0]         x_next;
    logic [9:0]         y_next;

    // Saturate a signed mouse coordinate into 0..lim.
    function automatic logic [9:0] clamp_axis(input logic signed [11:0] v,
                                              input logic [9:0]         lim);
        if (v[11])
            return '0;
        else if (v > $signed({2'b00, lim}))
            return lim;
        else
            return v[9:0];
    endfunction

    // Move cur toward tgt by at most MAX_STEP; 12-bit signed difference
    // covers the full +/-1023 range so nothing can wrap.
    function automatic logic [9:0] step_axis(input logic [9:0] cur,
                                             input logic [9:0] tgt);
        logic signed [11:0] diff;
        diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
        if (diff > STEP_POS)
            return cur + STEP_U;
        else if (diff < STEP_NEG)
            return cur - STEP_U;
        else
            return tgt;
    endfunction

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: one fixed walk IDLE->CAPTURE->CLAMP->MOVE->IDLE.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            IDLE:    if (enable && (frame_start || pending)) state_next = CAPTURE;
            CAPTURE: state_next = CLAMP;
            CLAMP:   state_next = MOVE;
            MOVE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Candidate cursor positions for the MOVE edge.
    always_comb begin
        x_next = step_axis(cursor_x, target_x);
        y_next = step_axis(cursor_y, target_y);
    end

    // Datapath: capture, clamp, move, pending-frame bookkeeping and flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending   <= 1'b0;
            cap_x     <= '0;
            cap_y     <= '0;
            target_x  <= RST_X;
            target_y  <= RST_Y;
            cursor_x  <= RST_X;
            cursor_y  <= RST_Y;
            pos_valid <= 1'b0;
            moving    <= 1'b0;
        end else begin
            pos_valid <= 1'b0;

            // In IDLE pending is either consumed by the start of a pass or
            // discarded because tracking is disabled; during a pass any
            // number of frame_start pulses collapse into one.
            if (state == IDLE)
                pending <= 1'b0;
            else if (frame_start)
                pending <= 1'b1;

            unique case (state)
                CAPTURE: begin
                    cap_x <= mouse_x_in;
                    cap_y <= mouse_y_in;
                end
                CLAMP: begin
                    target_x <= clamp_axis(cap_x, H_LIM);
                    target_y <= clamp_axis(cap_y, V_LIM);
                end
                MOVE: begin
                    cursor_x  <= x_next;
                    cursor_y  <= y_next;
                    pos_valid <= 1'b1;
                    moving    <= (x_next != target_x) || (y_next != target_y);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Self-checking bench for mouse_cursor_tracker.
// Expected cursor updates are queued as stimulus is issued; a monitor pops
// and compares on every pos_valid pulse. Timing and control outputs are
// checked directly by the stimulus process.
module tb_mouse_cursor_tracker;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       mov;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        frame_start;
    logic [11:0] mouse_x_in;
    logic [11:0] mouse_y_in;
    logic [9:0]  cursor_x;
    logic [9:0]  cursor_y;
    logic        pos_valid;
    logic        moving;
    logic        busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    mouse_cursor_tracker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .frame_start (frame_start),
        .mouse_x_in  (mouse_x_in),
        .mouse_y_in  (mouse_y_in),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .pos_valid   (pos_valid),
        .moving      (moving),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ex, input int ey, input logic em);
        exp_t e;
        e.x   = 10'(ex);
        e.y   = 10'(ey);
        e.mov = em;
        exp_q.push_back(e);
    endtask

    // One complete pass from a single frame_start, with latency checks.
    task automatic run_frame(input int ex, input int ey, input logic em);
        push_exp(ex, ey, em);
        frame_start = 1'b1;
        tick();                                   // edge N: IDLE -> CAPTURE
        frame_start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        tick();                                   // N+1: CAPTURE -> CLAMP
        tick();                                   // N+2: CLAMP -> MOVE
        check("pos_valid_early", 32'(pos_valid), 32'd0);
        tick();                                   // N+3: MOVE -> IDLE
        check("pos_valid_latency", 32'(pos_valid), 32'd1);
        tick();
        check("pos_valid_width", 32'(pos_valid), 32'd0);
        check("busy_back_idle", 32'(busy), 32'd0);
    endtask

    // Monitor: every pos_valid pulse must match the oldest queued update.
    always @(negedge clk) begin
        if (pos_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pos_valid_unexpected", 32'(pos_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cursor_x", 32'(cursor_x), 32'(e.x));
                check("cursor_y", 32'(cursor_y), 32'(e.y));
                check("moving", 32'(moving), 32'(e.mov));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ex;
        int ey;

        // Reset, with enable and frame_start asserted to prove reset wins.
        reset_n     = 1'b0;
        enable      = 1'b1;
        frame_start = 1'b1;
        mouse_x_in  = 12'd330;
        mouse_y_in  = 12'd240;
        repeat (3) tick();
        check("reset_cursor_x", 32'(cursor_x), 32'd320);
        check("reset_cursor_y", 32'(cursor_y), 32'd240);
        check("reset_pos_valid", 32'(pos_valid), 32'd0);
        check("reset_moving", 32'(moving), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        frame_start = 1'b0;
        reset_n     = 1'b1;
        tick();
        check("idle_after_reset", 32'(busy), 32'd0);

        // Basic tracking: 320->328 (step-limited), then 328->330 (snap).
        run_frame(328, 240, 1'b1);
        run_frame(330, 240, 1'b0);

        // Out-of-range target: X=-5 clamps to 0, Y=2000 clamps to 479.
        mouse_x_in = 12'hFFB;
        mouse_y_in = 12'd2000;
        for (int k = 1; k <= 42; k++) begin
            ex = (330 >= 8 * k) ? 330 - 8 * k : 0;
            ey = (240 + 8 * k <= 479) ? 240 + 8 * k : 479;
            run_frame(ex, ey, !(ex == 0 && ey == 479));
        end
        check("corner_x", 32'(cursor_x), 32'd0);
        check("corner_y", 32'(cursor_y), 32'd479);
        run_frame(0, 479, 1'b0);

        // frame_start during CAPTURE and CLAMP -> exactly one extra pass.
        mouse_x_in = 12'd100;
        mouse_y_in = 12'd100;
        push_exp(8, 471, 1'b1);
        push_exp(16, 463, 1'b1);
        frame_start = 1'b1;
        tick();                                   // N: -> CAPTURE
        tick();                                   // N+1: in CAPTURE, pending
        tick();                                   // N+2: in CLAMP, pending
        frame_start = 1'b0;
        tick();                                   // N+3: MOVE -> IDLE
        check("dbl_pv_first", 32'(pos_valid), 32'd1);
        check("dbl_busy_idle", 32'(busy), 32'd0);
        tick();                                   // N+4: IDLE -> CAPTURE
        check("dbl_busy_restart", 32'(busy), 32'd1);
        repeat (3) tick();                        // N+7: second MOVE
        check("dbl_pv_second", 32'(pos_valid), 32'd1);
        repeat (6) tick();
        check("dbl_no_third_pass", 32'(busy), 32'd0);

        // frame_start on the MOVE->IDLE edge is not lost.
        push_exp(24, 455, 1'b1);
        push_exp(32, 447, 1'b1);
        frame_start = 1'b1;
        tick();                                   // N
        frame_start = 1'b0;
        tick();                                   // N+1
        tick();                                   // N+2
        frame_start = 1'b1;
        tick();                                   // N+3: MOVE edge
        frame_start = 1'b0;
        check("edge_pv_first", 32'(pos_valid), 32'd1);
        check("edge_busy_gap", 32'(busy), 32'd0);
        tick();                                   // N+4
        check("edge_busy_restart", 32'(busy), 32'd1);
        repeat (3) tick();                        // N+7
        check("edge_pv_second", 32'(pos_valid), 32'd1);
        tick();
        check("edge_busy_done", 32'(busy), 32'd0);

        // Reset during CLAMP aborts the pass.
        frame_start = 1'b1;
        tick();                                   // -> CAPTURE
        frame_start = 1'b0;
        tick();                                   // -> CLAMP
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_cursor_x", 32'(cursor_x), 32'd320);
        check("abort_cursor_y", 32'(cursor_y), 32'd240);
        check("abort_pos_valid", 32'(pos_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (4) tick();
        check("abort_stays_idle", 32'(busy), 32'd0);

        // Disabled: frame_start ignored, nothing pending when re-enabled.
        enable = 1'b0;
        repeat (3) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            check("disabled_busy", 32'(busy), 32'd0);
            tick();
        end
        check("disabled_cursor_x", 32'(cursor_x), 32'd320);
        check("disabled_cursor_y", 32'(cursor_y), 32'd240);
        enable = 1'b1;
        repeat (8) tick();
        check("reenable_no_pass", 32'(busy), 32'd0);

        // Inputs changed after CAPTURE do not affect the current pass.
        mouse_x_in = 12'd330;
        mouse_y_in = 12'd240;
        push_exp(328, 240, 1'b1);
        frame_start = 1'b1;
        tick();                                   // -> CAPTURE
        frame_start = 1'b0;
        tick();                                   // inputs captured here
        mouse_x_in = 12'd0;
        mouse_y_in = 12'd0;
        tick();
        tick();
        check("late_input_pv", 32'(pos_valid), 32'd1);
        tick();

        // Dropping enable mid-pass still completes that pass.
        mouse_x_in = 12'd330;
        mouse_y_in = 12'd240;
        push_exp(330, 240, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        check("disable_mid_pass_pv", 32'(pos_valid), 32'd1);
        repeat (3) tick();
        check("disable_mid_pass_idle", 32'(busy), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
